// File: rtl/gray_count_readout_if.sv
// Channel-side bus of gray_count_readout: gray count and frame strobe in,
// framed serial readout out. The DUT takes the slave modport.
interface gray_count_readout_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] gray_in;
  logic             sample;
  logic             sout;
  logic             sframe;
  logic             done;
  logic             miss;

  modport master (
    output gray_in,
    output sample,
    input  sout,
    input  sframe,
    input  done,
    input  miss
  );

  modport slave (
    input  gray_in,
    input  sample,
    output sout,
    output sframe,
    output done,
    output miss
  );
endinterface

// File: rtl/gray_count_readout.sv
// Samples an asynchronous gray count, converts it to binary, and shifts the
// per-frame delta out MSB-first. Define GRAY_READOUT_RAW_EN to send raw counts.
module gray_count_readout #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_count_readout_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2,
    SHIFT   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] gray_s;
  logic [WIDTH-1:0] gray_cap;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] frame_word;
  logic [CNT_W-1:0] bit_cnt;
  logic             sout_q;
  logic             sframe_q;
  logic             done_q;
  logic             miss_q;
`ifndef GRAY_READOUT_RAW_EN
  logic [WIDTH-1:0] prev_bin;
`endif

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The gray bus changes one bit at a time, so a plain flop chain is enough:
  // a sample taken mid-transition resolves to either the old or new count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gray_s = sync_q[SYNC_STAGES-1];

`ifdef GRAY_READOUT_RAW_EN
  always_comb begin
    frame_word = bin;
  end
`else
  always_comb begin
    frame_word = bin - prev_bin;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gray_cap <= '0;
      bin      <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
      miss_q   <= 1'b0;
`ifndef GRAY_READOUT_RAW_EN
      prev_bin <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.sample && (state != IDLE)) begin
        miss_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.sample) begin
            gray_cap <= gray_s;
            state    <= CONVERT;
          end
        end

        CONVERT: begin
          bin   <= gray_to_bin(gray_cap);
          state <= LOAD;
        end

        // The first serial bit is registered here so sout lines up with sframe.
        LOAD: begin
          shreg    <= frame_word;
          sout_q   <= frame_word[WIDTH-1];
          sframe_q <= 1'b1;
          bit_cnt  <= CNT_W'(WIDTH - 1);
`ifndef GRAY_READOUT_RAW_EN
          prev_bin <= bin;
`endif
          state    <= SHIFT;
        end

        SHIFT: begin
          if (bit_cnt == '0) begin
            sout_q   <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= IDLE;
          end else begin
            shreg   <= shreg << 1;
            sout_q  <= shreg[WIDTH-2];
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sout   = sout_q;
  assign bus.sframe = sframe_q;
  assign bus.done   = done_q;
  assign bus.miss   = miss_q;

endmodule

// File: tb/tb_gray_count_readout.sv
// Directed bench for gray_count_readout (WIDTH=8, SYNC_STAGES=2); expected
// frames follow GRAY_READOUT_RAW_EN when it is defined.
module tb_gray_count_readout;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic exp_miss;

  gray_count_readout_if #(.WIDTH(8)) bus ();

  gray_count_readout #(
    .WIDTH       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gray;
    int         settle;
    logic [7:0] exp_delta;
    logic [7:0] exp_raw;
  } vec_t;

  vec_t table_v [4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] gray, input int settle);
    bus.gray_in = gray;
    repeat (settle) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call anywhere in the cycle that is to be frame cycle 0; returns after the
  // negedge of cycle 11 (the done cycle).
  task automatic runFrame(input logic [7:0] exp_delta, input logic [7:0] exp_raw,
                          input logic [7:0] next_gray, input int inj);
    logic [7:0] expw;
`ifdef GRAY_READOUT_RAW_EN
    expw = exp_raw;
`else
    expw = exp_delta;
`endif
    bus.sample = 1'b1;
    @(posedge clk);
    #1;
    bus.sample = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 1) bus.gray_in = next_gray;
      if (c == inj) bus.sample = 1'b1;
      @(negedge clk);
      if (inj != 0 && c > inj) exp_miss = 1'b1;
      if (c >= 3 && c <= 10) begin
        checkOutput($sformatf("sframe_c%0d", c), {31'd0, bus.sframe}, 32'd1);
        checkOutput($sformatf("sout_c%0d", c), {31'd0, bus.sout}, {31'd0, expw[10-c]});
      end else begin
        checkOutput($sformatf("sframe_c%0d", c), {31'd0, bus.sframe}, 32'd0);
        checkOutput($sformatf("sout_c%0d", c), {31'd0, bus.sout}, 32'd0);
      end
      checkOutput($sformatf("done_c%0d", c), {31'd0, bus.done}, (c == 11) ? 32'd1 : 32'd0);
      checkOutput($sformatf("miss_c%0d", c), {31'd0, bus.miss}, {31'd0, exp_miss});
      if (c < 11) begin
        @(posedge clk);
        #1;
        bus.sample = 1'b0;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_miss    = 1'b0;
    rst         = 1'b1;
    bus.sample  = 1'b0;
    bus.gray_in = 8'h00;

    table_v[0] = '{gray: 8'h07, settle: 3, exp_delta: 8'd5,   exp_raw: 8'd5};
    table_v[1] = '{gray: 8'h0A, settle: 3, exp_delta: 8'd7,   exp_raw: 8'd12};
    table_v[2] = '{gray: 8'h87, settle: 3, exp_delta: 8'd238, exp_raw: 8'd250};
    table_v[3] = '{gray: 8'h02, settle: 3, exp_delta: 8'd9,   exp_raw: 8'd3};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_sout",   {31'd0, bus.sout},   32'd0);
    checkOutput("reset_sframe", {31'd0, bus.sframe}, 32'd0);
    checkOutput("reset_done",   {31'd0, bus.done},   32'd0);
    checkOutput("reset_miss",   {31'd0, bus.miss},   32'd0);

    $display("[TB] table frames");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(table_v[i].gray, table_v[i].settle);
      runFrame(table_v[i].exp_delta, table_v[i].exp_raw, table_v[i].gray, 0);
    end

    // Back-to-back: second sample lands in the done cycle of the first.
    $display("[TB] back-to-back frames");
    applyStimulus(8'h04, 3);
    runFrame(8'd4, 8'd7, 8'h0A, 0);
    runFrame(8'd5, 8'd12, 8'h0A, 0);

    // Sample at cycle 5 is ignored but sets miss; gray moves to 250 meanwhile.
    $display("[TB] sample while busy");
    applyStimulus(8'h0F, 3);
    runFrame(8'd254, 8'd10, 8'h87, 5);
    applyStimulus(8'h87, 3);
    runFrame(8'd240, 8'd250, 8'h87, 0);

    // Reset in cycle 6 of a frame abandons it.
    $display("[TB] reset mid-frame");
    applyStimulus(8'h02, 3);
    bus.sample = 1'b1;
    @(posedge clk);
    #1;
    bus.sample = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_miss = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_sframe", {31'd0, bus.sframe}, 32'd0);
    checkOutput("rst_mid_sout",   {31'd0, bus.sout},   32'd0);
    checkOutput("rst_mid_done",   {31'd0, bus.done},   32'd0);
    checkOutput("rst_mid_miss",   {31'd0, bus.miss},   32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_mid_nodone_%0d", k), {31'd0, bus.done}, 32'd0);
    end
    applyStimulus(8'h0A, 3);
    runFrame(8'd12, 8'd12, 8'h0A, 0);

    // Reset and sample together: no frame may start.
    $display("[TB] reset with sample");
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.sample = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.sample = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_smp_sframe_%0d", k), {31'd0, bus.sframe}, 32'd0);
      checkOutput($sformatf("rst_smp_done_%0d", k),   {31'd0, bus.done},   32'd0);
    end
    applyStimulus(8'h0A, 3);
    runFrame(8'd12, 8'd12, 8'h0A, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
